// File: rtl/entity_loader_if.sv
// Byte-serial loader bus: packet byte input, frame sync level, and the
// committed entity table with its status pulses.
interface entity_loader_if #(
  parameter int unsigned NUM_SLOTS = 8
);
  logic [7:0]              data_in;
  logic                    data_valid;
  logic                    frame_sync;
  logic [NUM_SLOTS*14-1:0] entities;
  logic                    commit;
  logic                    error;
  logic                    busy;

  // Packet source / table consumer side
  modport master (
    output data_in, data_valid, frame_sync,
    input  entities, commit, error, busy
  );

  // Loader side
  modport slave (
    input  data_in, data_valid, frame_sync,
    output entities, commit, error, busy
  );
endinterface

// File: rtl/entity_loader.sv
// entity_loader: assembles 3-byte update packets into a shadow table of
// 14-bit entity descriptors and copies it to the active table on each
// rising edge of frame_sync, so the frame-buffer never sees a torn update.
// Optional feature macro: ENTITY_LOADER_CLEAR_EN (single byte 8'hC0 in IDLE
// resets every shadow slot to "unused").
module entity_loader #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic           clk,
  input logic           rst_n,
  entity_loader_if.slave bus
);

  localparam int unsigned DW    = 14;
  localparam int unsigned GAP_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] UNUSED = 14'h3C00;

  typedef enum logic [1:0] {IDLE, HDR, HI} state_t;

  state_t                  state;
  logic [3:0]              slot;
  logic [5:0]              hi6;
  logic [GAP_W-1:0]        gap;
  logic                    dirty;
  logic                    fs_q;
  logic                    commit;
  logic                    error;
  logic                    busy;
  logic [DW-1:0]           shadow [NUM_SLOTS];
  logic [NUM_SLOTS*DW-1:0] active;

  logic rise_c;
  logic hdr_ok_c;
  logic bad_hdr_c;
  logic wr_c;
  logic timeout_c;

  assign rise_c    = bus.frame_sync & ~fs_q;
  assign hdr_ok_c  = (bus.data_in[7:4] == 4'hA) &&
                     ({1'b0, bus.data_in[3:0]} < 5'(NUM_SLOTS));
  assign wr_c      = (state == HI) && bus.data_valid;
  // Fires on the edge where the idle-cycle count would reach TIMEOUT
  assign timeout_c = (state != IDLE) && !bus.data_valid &&
                     (gap == GAP_W'(TIMEOUT - 1));

`ifdef ENTITY_LOADER_CLEAR_EN
  logic clr_c;
  assign clr_c     = (state == IDLE) && bus.data_valid && (bus.data_in == 8'hC0);
  assign bad_hdr_c = !hdr_ok_c && !clr_c;
`else
  assign bad_hdr_c = !hdr_ok_c;
`endif

  // Packet receive FSM with idle-gap timeout and registered busy/error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= 4'd0;
      hi6   <= 6'd0;
      gap   <= '0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          gap <= '0;
          if (bus.data_valid) begin
            if (hdr_ok_c) begin
              slot  <= bus.data_in[3:0];
              state <= HDR;
              busy  <= 1'b1;
            end else if (bad_hdr_c) begin
              error <= 1'b1;
            end
          end
        end
        HDR: begin
          if (bus.data_valid) begin
            hi6   <= bus.data_in[5:0];
            gap   <= '0;
            state <= HI;
          end else if (timeout_c) begin
            gap   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        HI: begin
          if (bus.data_valid) begin
            gap   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timeout_c) begin
            gap   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            gap <= gap + GAP_W'(1);
          end
        end
        default: begin
          gap   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow writes, frame-boundary commit of shadow to active, dirty tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) shadow[k] <= UNUSED;
      active <= {NUM_SLOTS{UNUSED}};
      dirty  <= 1'b0;
      fs_q   <= 1'b0;
      commit <= 1'b0;
    end else begin
      fs_q   <= bus.frame_sync;
      commit <= 1'b0;
      // Copy uses pre-edge shadow; a same-edge write keeps dirty set below
      if (rise_c && dirty) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) active[k*DW +: DW] <= shadow[k];
        commit <= 1'b1;
        dirty  <= 1'b0;
      end
      if (wr_c) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
          if (slot == 4'(k)) shadow[k] <= {hi6, bus.data_in};
        end
        dirty <= 1'b1;
      end
`ifdef ENTITY_LOADER_CLEAR_EN
      if (clr_c) begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) shadow[k] <= UNUSED;
        dirty <= 1'b1;
      end
`endif
    end
  end

  assign bus.entities = active;
  assign bus.commit   = commit;
  assign bus.error    = error;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_entity_loader.sv
// Scoreboard bench for entity_loader: stimulus pushes expected commit tables
// and error events; a negedge monitor pops and compares on every pulse.
module tb_entity_loader;

  localparam int unsigned NS = 8;
  localparam int unsigned TO = 255;
  localparam int unsigned EW = NS * 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  entity_loader_if #(.NUM_SLOTS(NS)) bus ();

  entity_loader #(.NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [EW-1:0] exp_commit_q [$];
  int            exp_err_q    [$];
  logic [EW-1:0] act;
  logic [EW-1:0] mon_e;
  int            mon_tag;
  logic [7:0]    seq [$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [EW-1:0] all_unused();
    logic [EW-1:0] r;
    for (int k = 0; k < int'(NS); k++) r[k*14 +: 14] = 14'h3C00;
    return r;
  endfunction

  // Monitor: every commit/error pulse must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.commit) begin
        if (exp_commit_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_commit: got table %h want no commit", bus.entities);
        end else begin
          mon_e = exp_commit_q.pop_front();
          chk("commit_table", 128'(bus.entities), 128'(mon_e));
        end
      end
      if (bus.error) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_error: got error=1 want 0");
        end else begin
          mon_tag = exp_err_q.pop_front();
          chk($sformatf("busy_at_error_%0d", mon_tag), 128'(bus.busy), 128'(0));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.data_in = b;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input bit rise_last);
    @(posedge clk); #1;
    bus.data_valid = 1'b1; bus.data_in = b0;
    @(posedge clk); #1;
    bus.data_in = b1;
    @(posedge clk); #1;
    bus.data_in = b2;
    if (rise_last) bus.frame_sync = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    if (rise_last) begin
      repeat (2) @(posedge clk);
      #1 bus.frame_sync = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Bytes of seq on consecutive cycles with no gap
  task automatic send_seq();
    @(posedge clk); #1;
    for (int i = 0; i < seq.size(); i++) begin
      bus.data_valid = 1'b1;
      bus.data_in = seq[i];
      @(posedge clk); #1;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic frame();
    @(posedge clk); #1;
    bus.frame_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    act = all_unused();
    chk("reset_entities", 128'(bus.entities), 128'(act));
    chk("reset_commit", 128'(bus.commit), 128'(0));
    chk("reset_error", 128'(bus.error), 128'(0));
    chk("reset_busy", 128'(bus.busy), 128'(0));

    // Basic write, held in shadow until the frame boundary
    send_byte(8'hA2);
    chk("busy_after_hdr", 128'(bus.busy), 128'(1));
    send_byte(8'h2D);
    send_byte(8'h47);
    chk("busy_after_pkt", 128'(bus.busy), 128'(0));
    chk("no_change_before_rise", 128'(bus.entities), 128'(act));
    act[2*14 +: 14] = 14'h2D47;
    exp_commit_q.push_back(act);
    frame();
    chk("slot2_after_rise", 128'(bus.entities), 128'(act));

    // Bad slot and bad header; no dirty so next rise commits nothing
    exp_err_q.push_back(1); send_byte(8'hA9);
    exp_err_q.push_back(2); send_byte(8'h55);
    exp_err_q.push_back(3); send_byte(8'hA8);
    frame();
    chk("table_kept_after_bad", 128'(bus.entities), 128'(act));

    // Timeout mid-packet, then a clean packet to the same slot
    send_byte(8'hA1);
    send_byte(8'h3F);
    chk("busy_before_timeout", 128'(bus.busy), 128'(1));
    exp_err_q.push_back(4);
    repeat (TO + 5) @(posedge clk);
    #1 chk("busy_after_timeout", 128'(bus.busy), 128'(0));
    send_pkt(8'hA1, 8'h05, 8'h10, 1'b0);
    act[1*14 +: 14] = 14'h0510;
    exp_commit_q.push_back(act);
    frame();

    // byte2 accepted on the rise edge: commit excludes it, next rise includes it
    send_pkt(8'hA3, 8'h10, 8'h01, 1'b0);
    act[3*14 +: 14] = 14'h1001;
    exp_commit_q.push_back(act);
    send_pkt(8'hA0, 8'h04, 8'h80, 1'b1);
    chk("slot0_unchanged_at_rise", 128'(bus.entities[13:0]), 128'(14'h3C00));
    act[0 +: 14] = 14'h0480;
    exp_commit_q.push_back(act);
    frame();

`ifdef ENTITY_LOADER_CLEAR_EN
    send_byte(8'hC0);
    act = all_unused();
    exp_commit_q.push_back(act);
    frame();
`else
    exp_err_q.push_back(5);
    send_byte(8'hC0);
    frame();
`endif
    chk("table_after_c0", 128'(bus.entities), 128'(act));

    // Zero-gap packets, last write wins, ignored byte1[7:6], top slot
    seq = '{8'hA5, 8'h3F, 8'hFF, 8'hA5, 8'hE1, 8'h22, 8'hA7, 8'h0F, 8'hAA};
    send_seq();
    act[5*14 +: 14] = 14'h2122;
    act[7*14 +: 14] = 14'h0FAA;
    exp_commit_q.push_back(act);
    frame();

    // Reset mid-packet drops everything
    send_byte(8'hA4);
    chk("busy_before_reset", 128'(bus.busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    act = all_unused();
    chk("busy_in_reset", 128'(bus.busy), 128'(0));
    chk("entities_in_reset", 128'(bus.entities), 128'(act));
    @(posedge clk); #1 rst_n = 1'b1;
    exp_err_q.push_back(6);
    send_byte(8'h2D);
    send_pkt(8'hA6, 8'h2A, 8'h5B, 1'b0);
    act[6*14 +: 14] = 14'h2A5B;
    exp_commit_q.push_back(act);
    frame();

    repeat (5) @(posedge clk);
    #1;
    chk("pending_commits", 128'(exp_commit_q.size()), 128'(0));
    chk("pending_errors", 128'(exp_err_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
